ysyx_24110006_lsu: RTL
======================

Name: ysyx_24110006_lsu

Overview:
Load/store unit that consumes the execute stage's memory request (address, store data, mask, read type, read/write enables) and performs it as an AXI4-Lite manager transaction. It aligns store data and strobes to the byte address, and sign- or zero-extends load data. Results and faults go to write-back over a valid/ready handshake. One request is in flight at a time.

Parameters:
ADDR_W, 32, byte address width (data width fixed at 32)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
i_valid  in  1  request valid from EXU stage
o_ready  out  1  LSU can accept a request (idle)
i_addr  in  ADDR_W  byte address (EXU result)
i_wdata  in  32  store data, unshifted (rs2)
i_mem_ren  in  1  load request
i_mem_wen  in  1  store request
i_wmask  in  4  unshifted store mask: 0001 sb, 0011 sh, 1111 sw
i_read_t  in  3  funct3 of load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
o_valid  out  1  result valid to write-back
i_ready  in  1  write-back accepts result
o_rdata  out  32  extended load data (0 for stores, non-memory requests and faults)
o_fault  out  1  misaligned, illegal or bus-error request
araddr/arvalid/arready  out/out/in  ADDR_W/1/1  AXI read address channel
rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  AXI read data channel
awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  AXI write address channel
wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  AXI write data channel
bresp/bvalid/bready  in/in/out  2/1/1  AXI write response channel

Behaviour:
- Reset (async): state IDLE; all of o_valid, arvalid, rvalid-ready, awvalid, wvalid, bready, o_fault are 0; o_rdata 0. A bus transaction in flight is abandoned.
- States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- IDLE: o_ready=1. On i_valid, latch every request field and decide the next state:
  - ren&wen both set, or illegal read_t (011/110/111) → DONE with fault.
  - Misaligned access → DONE with fault, no bus traffic. Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0; mask 0011 or 1111 are checked the same way for stores.
  - ren → RADDR. wen → WREQ. Neither → DONE, rdata 0, no fault.
- RADDR: arvalid=1, araddr=addr with addr[1:0] cleared. On arready → RDATA. arvalid stays stable until the handshake.
- RDATA: rready=1. On rvalid, capture the extended data: lane = rdata >> 8*addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw pass through. A nonzero rresp gives fault=1 and data 0. → DONE.
- WREQ: awvalid=1 and wvalid=1 independently. awaddr = word-aligned addr, wstrb = wmask << addr[1:0], wdata = i_wdata << 8*addr[1:0].
  - Each valid drops after its own handshake (tracked by two done flags). AW and W may complete in either order or the same cycle.
  - When both are done → WRESP.
- WRESP: bready=1. On bvalid → DONE; a nonzero bresp gives fault=1.
- DONE: o_valid=1, o_rdata/o_fault stable. On i_ready → IDLE. No new request is accepted in the DONE cycle.
- Latency, zero-wait slave (arready/awready/wready=1, rvalid/bvalid one cycle after address): accept at t0, address handshake t1, data/resp t2, o_valid t3.
- All bus outputs and o_valid/o_rdata/o_fault are registered.

Decomposition:
- Shared package: state enum; READ_T constants (LB, LH, LW, LBU, LHU); AXI resp codes OKAY=00, SLVERR=10, DECERR=11.
- Sub-module ysyx_24110006_lsu_align, combinational: misalignment check, wstrb/wdata shift, load lane extract and extend.

Test Plan:
- lbu addr 0x80000003, rdata 0x8877_6655 → araddr 0x80000000, o_rdata 0x00000088, o_valid at t3, o_fault 0.
- lh addr 0x80000002, rdata 0x8001_1234 → o_rdata 0xFFFF8001; lw addr 0x80000002 → o_fault=1, arvalid never asserted, o_valid at t1.
- sb addr 0x80000001 wdata 0x000000AB → wstrb 0010, wdata 0x0000AB00. Hold wready=0 for 3 cycles with awready=1 → awvalid drops after 1 cycle, wvalid held, result after bvalid.
- Store with awready/wready both delayed and completing in the same cycle, then bresp=10 → exactly one B handshake, o_fault=1.
- i_ready held 0 for 4 cycles in DONE → o_valid/o_rdata stable, o_ready=0. Assert reset during RDATA → all valids 0 immediately, o_ready=1 after release.
- Request with ren=wen=0 → o_valid next cycle, o_rdata 0, no bus activity.

Source files
------------

// File: rtl/ysyx_24110006_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, load
// funct3 encodings and AXI response codes.
package ysyx_24110006_lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_RDATA,
        S_WREQ,
        S_WRESP,
        S_DONE
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic read_t_legal(input logic [2:0] t);
        return (t == LB) || (t == LH) || (t == LW) || (t == LBU) || (t == LHU);
    endfunction

endpackage

// File: rtl/ysyx_24110006_lsu_align.sv
// Combinational byte-lane logic: alignment check and store shifting for the
// incoming request, lane extraction and extension for the returning load data.
module ysyx_24110006_lsu_align
    import ysyx_24110006_lsu_pkg::*;
(
    input  logic [1:0]  req_off_i,
    input  logic        req_ren_i,
    input  logic        req_wen_i,
    input  logic [2:0]  req_read_t_i,
    input  logic [3:0]  req_wmask_i,
    input  logic [31:0] req_wdata_i,
    output logic        misaligned_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  ld_off_i,
    input  logic [2:0]  ld_read_t_i,
    input  logic [31:0] ld_bus_i,
    output logic [31:0] ld_data_o
);

    logic               half_acc;
    logic               word_acc;
    logic [31:0]        lane;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    always_comb begin
        half_acc = (req_ren_i && ((req_read_t_i == LH) || (req_read_t_i == LHU)))
                || (req_wen_i && (req_wmask_i == 4'b0011));
        word_acc = (req_ren_i && (req_read_t_i == LW))
                || (req_wen_i && (req_wmask_i == 4'b1111));
        misaligned_o = (half_acc && req_off_i[0]) || (word_acc && (req_off_i != 2'b00));
    end

    assign wstrb_o = req_wmask_i << req_off_i;
    assign wdata_o = req_wdata_i << {req_off_i, 3'b000};

    assign lane   = ld_bus_i >> {ld_off_i, 3'b000};
    assign lane_b = lane[7:0];
    assign lane_h = lane[15:0];

    always_comb begin
        case (ld_read_t_i)
            LB:      ld_data_o = 32'(lane_b);
            LH:      ld_data_o = 32'(lane_h);
            LBU:     ld_data_o = {24'b0, lane[7:0]};
            LHU:     ld_data_o = {16'b0, lane[15:0]};
            default: ld_data_o = lane;
        endcase
    end

endmodule

// File: rtl/ysyx_24110006_lsu.sv
// Load/store unit: accepts one EXU memory request at a time and performs it as
// an AXI4-Lite manager transaction, returning data/fault over valid/ready.
module ysyx_24110006_lsu
    import ysyx_24110006_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic              i_mem_ren,
    input  logic              i_mem_wen,
    input  logic [3:0]        i_wmask,
    input  logic [2:0]        i_read_t,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_rdata,
    output logic              o_fault,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    lsu_state_e        state_q;
    logic [1:0]        off_q;
    logic [2:0]        read_t_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic              aw_done_q, w_done_q;
    logic              o_valid_q, fault_q;
    logic [31:0]       rdata_q;

    logic              req_misaligned, req_illegal;
    logic [3:0]        st_wstrb;
    logic [31:0]       st_wdata, ld_data, rdata_d;
    logic              aw_hs, w_hs;

    ysyx_24110006_lsu_align u_align (
        .req_off_i    (i_addr[1:0]),
        .req_ren_i    (i_mem_ren),
        .req_wen_i    (i_mem_wen),
        .req_read_t_i (i_read_t),
        .req_wmask_i  (i_wmask),
        .req_wdata_i  (i_wdata),
        .misaligned_o (req_misaligned),
        .wstrb_o      (st_wstrb),
        .wdata_o      (st_wdata),
        .ld_off_i     (off_q),
        .ld_read_t_i  (read_t_q),
        .ld_bus_i     (rdata),
        .ld_data_o    (ld_data)
    );

    assign req_illegal = i_mem_ren && (i_mem_wen || !read_t_legal(i_read_t));
    assign rdata_d     = (rresp == RESP_OKAY) ? ld_data : 32'b0;
    assign aw_hs       = awvalid_q && awready;
    assign w_hs        = wvalid_q && wready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            off_q     <= 2'b0;
            read_t_q  <= 3'b0;
            addr_q    <= '0;
            wdata_q   <= 32'b0;
            wstrb_q   <= 4'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            o_valid_q <= 1'b0;
            fault_q   <= 1'b0;
            rdata_q   <= 32'b0;
        end else begin
            unique case (state_q)
                S_IDLE: if (i_valid) begin
                    off_q    <= i_addr[1:0];
                    read_t_q <= i_read_t;
                    addr_q   <= {i_addr[ADDR_W-1:2], 2'b00};
                    wdata_q  <= st_wdata;
                    wstrb_q  <= st_wstrb;
                    rdata_q  <= 32'b0;
                    fault_q  <= 1'b0;
                    // Faulting requests never touch the bus.
                    if (req_illegal || req_misaligned) begin
                        fault_q   <= 1'b1;
                        o_valid_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else if (i_mem_ren) begin
                        arvalid_q <= 1'b1;
                        state_q   <= S_RADDR;
                    end else if (i_mem_wen) begin
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= S_WREQ;
                    end else begin
                        o_valid_q <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_RADDR: if (arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= S_RDATA;
                end
                S_RDATA: if (rvalid) begin
                    rready_q  <= 1'b0;
                    rdata_q   <= rdata_d;
                    fault_q   <= (rresp != RESP_OKAY);
                    o_valid_q <= 1'b1;
                    state_q   <= S_DONE;
                end
                S_WREQ: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WRESP;
                    end
                end
                S_WRESP: if (bvalid) begin
                    bready_q  <= 1'b0;
                    fault_q   <= (bresp != RESP_OKAY);
                    o_valid_q <= 1'b1;
                    state_q   <= S_DONE;
                end
                S_DONE: if (i_ready) begin
                    o_valid_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ready = (state_q == S_IDLE);
    assign o_valid = o_valid_q;
    assign o_rdata = rdata_q;
    assign o_fault = fault_q;
    assign araddr  = addr_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign awaddr  = addr_q;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule
